// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//
// APB3 completer holding a small word-addressed register bank. Every
// transfer waits a fixed number of ACCESS-phase cycles, and illegal accesses
// are reported on PSLVERR. It is the reference APB endpoint placed behind the
// AHB-to-APB bridge.
//
// Register map (word index = PADDR[ADDR_WIDTH-1:2], PADDR[1:0] must be 0):
//   0 .. NUM_REGS-2 : read/write data registers, reset to 0
//   NUM_REGS-1      : read-only count of committed writes (wraps)
//
// Optional feature macro: APB_SLAVE_PSTRB_EN
//   defined   -> PSTRB port exists; writes update only strobed byte lanes
//   undefined -> no PSTRB port; writes update the whole word
//
// Ports:
//   PCLK     in   clock
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   completer select
//   PENABLE  in   ACCESS-phase marker
//   PADDR    in   [ADDR_WIDTH-1:0] byte address
//   PWRITE   in   1 = write, 0 = read
//   PWDATA   in   [DATA_WIDTH-1:0] write data
//   PSTRB    in   [DATA_WIDTH/8-1:0] byte strobes (APB_SLAVE_PSTRB_EN only)
//   PRDATA   out  [DATA_WIDTH-1:0] read data, 0 outside the READY cycle
//   PREADY   out  transfer completes this cycle
//   PSLVERR  out  transfer error, valid with PREADY
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLAVE_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [IW-1:0]           lat_idx;
  logic                    lat_legal;
  logic                    lat_write;
  logic [DATA_WIDTH-1:0]   lat_wdata;
`ifdef APB_SLAVE_PSTRB_EN
  logic [NB-1:0]           lat_strb;
`endif
  logic [NB-1:0]           wr_strb;

  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic [ADDR_WIDTH-3:0]   setup_idx;
  logic                    setup_legal;
  logic [IW-1:0]           sel_idx;
  logic                    sel_legal;
  logic                    sel_write;
  logic [DATA_WIDTH-1:0]   rd_value;
  logic [DATA_WIDTH-1:0]   old_data;
  logic [DATA_WIDTH-1:0]   merged_data;
  logic                    commit;

  assign setup_idx = PADDR[ADDR_WIDTH-1:2];

`ifdef APB_SLAVE_PSTRB_EN
  assign wr_strb = lat_strb;
`else
  assign wr_strb = '1;
`endif

  // Legality is judged on the full word index so that addresses above the
  // bank never alias onto a real register. The counter slot is read-only.
  always_comb begin
    setup_legal = (PADDR[1:0] == 2'b00) &&
                  (setup_idx < (ADDR_WIDTH-2)'(NUM_REGS));
    if (PWRITE && (setup_idx == (ADDR_WIDTH-2)'(NUM_REGS - 1))) begin
      setup_legal = 1'b0;
    end
  end

  // READY can be entered straight from IDLE (no wait states), in which case
  // the access attributes are still on the bus rather than in the latches.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_idx   = setup_idx[IW-1:0];
      sel_legal = setup_legal;
      sel_write = PWRITE;
    end else begin
      sel_idx   = lat_idx;
      sel_legal = lat_legal;
      sel_write = lat_write;
    end
    rd_value = '0;
    if (sel_legal && !sel_write) begin
      rd_value = regs[sel_idx];
    end
  end

  // Byte-lane merge of the latched write data with the current contents.
  always_comb begin
    old_data    = regs[lat_idx];
    merged_data = old_data;
    for (int b = 0; b < NB; b++) begin
      if (wr_strb[b]) begin
        merged_data[b*8 +: 8] = lat_wdata[b*8 +: 8];
      end
    end
  end

  assign commit = (state == ST_READY) && lat_write && lat_legal;

  // Transfer sequencer. Outputs are registered and loaded on the edge that
  // enters ST_READY, so they hold for exactly that one cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      lat_idx   <= '0;
      lat_legal <= 1'b0;
      lat_write <= 1'b0;
      lat_wdata <= '0;
`ifdef APB_SLAVE_PSTRB_EN
      lat_strb  <= '0;
`endif
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      PRDATA    <= '0;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) begin
            lat_idx   <= setup_idx[IW-1:0];
            lat_legal <= setup_legal;
            lat_write <= PWRITE;
            lat_wdata <= PWDATA;
`ifdef APB_SLAVE_PSTRB_EN
            lat_strb  <= PSTRB;
`endif
            wait_cnt  <= 4'(WAIT_STATES);
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_READY;
              PREADY  <= 1'b1;
              PSLVERR <= !sel_legal;
              PRDATA  <= rd_value;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (!PSEL) begin
            state <= ST_IDLE;
          end else if (wait_cnt == 4'd1) begin
            state   <= ST_READY;
            PREADY  <= 1'b1;
            PSLVERR <= !sel_legal;
            PRDATA  <= rd_value;
          end
        end
        ST_READY: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register bank. The last slot is the write counter; it bumps on every
  // committed write, including strobe-less ones.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (lat_idx == IW'(i)) begin
          regs[i] <= merged_data;
        end
      end
      regs[NUM_REGS-1] <= regs[NUM_REGS-1] + DATA_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_regfile
//
// Directed bench for apb_slave_regfile. Three instances share the address and
// data lines but have private PSEL lines: dut0 uses WAIT_STATES=1, dut1 uses
// WAIT_STATES=0, dut2 uses WAIT_STATES=15. Byte-strobe vectors run only when
// APB_SLAVE_PSTRB_EN is defined.
// ---------------------------------------------------------------------------
module tb_apb_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
`ifdef APB_SLAVE_PSTRB_EN
  logic [3:0]  pstrb;
`endif
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.WAIT_STATES(1)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_slave_regfile #(.WAIT_STATES(0)) dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  apb_slave_regfile #(.WAIT_STATES(15)) dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable),
    .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
`ifdef APB_SLAVE_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2])
  );

  // Single comparison point: counts and reports each check.
  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drives SETUP then the first ACCESS cycle; returns #1 after that edge.
  task automatic start_xfer(input int d, input logic [31:0] addr,
                            input logic wr, input logic [31:0] wdata);
    @(posedge clk); #1;
    psel    = 3'b000;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
  endtask

  // One full transfer. cycles counts the whole transfer, SETUP included.
  task automatic apply_stimulus(input int d, input logic [31:0] addr,
                                input logic wr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int cycles);
    bit done;
    start_xfer(d, addr, wr, wdata);
    cycles = 2;
    rdata  = '0;
    err    = 1'b0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pready[d]) begin
        rdata = prdata[d];
        err   = pslverr[d];
        done  = 1'b1;
      end else if (cycles >= 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout: no PREADY from dut%0d after %0d cycles", d, cycles);
        cycles = -1;
        done   = 1'b1;
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    psel    = 3'b000;
    penable = 1'b0;
  endtask

  task automatic release_reset();
    go_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cy;

    rst_n   = 1'b0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
`ifdef APB_SLAVE_PSTRB_EN
    pstrb   = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_pready", 32'(pready[0]), 32'd0);
    check_output("rst_pslverr", 32'(pslverr[0]), 32'd0);
    check_output("rst_prdata", prdata[0], 32'h0);
    rst_n = 1'b1;

    // First read after reset: READY in the 3rd transfer cycle.
    apply_stimulus(0, 32'h00, 1'b0, 32'h0, rd, er, cy);
    check_output("rd0_cycles", 32'(cy), 32'd3);
    check_output("rd0_data", rd, 32'h0);
    check_output("rd0_err", 32'(er), 32'd0);

    // Write then back-to-back read, then the counter.
    apply_stimulus(0, 32'h04, 1'b1, 32'hDEADBEEF, rd, er, cy);
    check_output("wr4_err", 32'(er), 32'd0);
    check_output("wr4_cycles", 32'(cy), 32'd3);
    apply_stimulus(0, 32'h04, 1'b0, 32'h0, rd, er, cy);
    check_output("rd4_data", rd, 32'hDEADBEEF);
    apply_stimulus(0, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("cnt1_data", rd, 32'd1);
    check_output("cnt1_err", 32'(er), 32'd0);

    // Illegal accesses: counter write, out of range, misaligned.
    apply_stimulus(0, 32'h3C, 1'b1, 32'h00000055, rd, er, cy);
    check_output("wr3c_err", 32'(er), 32'd1);
    check_output("wr3c_data", rd, 32'h0);
    apply_stimulus(0, 32'h40, 1'b1, 32'hA5A5A5A5, rd, er, cy);
    check_output("wr40_err", 32'(er), 32'd1);
    apply_stimulus(0, 32'h06, 1'b0, 32'h0, rd, er, cy);
    check_output("rd06_err", 32'(er), 32'd1);
    check_output("rd06_data", rd, 32'h0);
    apply_stimulus(0, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("cnt_after_err", rd, 32'd1);
    apply_stimulus(0, 32'h00, 1'b0, 32'h0, rd, er, cy);
    check_output("rd0_no_alias", rd, 32'h0);
    apply_stimulus(0, 32'h04, 1'b0, 32'h0, rd, er, cy);
    check_output("rd4_kept", rd, 32'hDEADBEEF);

    // Outputs drop back to zero once the READY cycle is over.
    go_idle();
    @(negedge clk);
    check_output("idle_pready", 32'(pready[0]), 32'd0);
    check_output("idle_prdata", prdata[0], 32'h0);

    // Read-after-write on consecutive transfers.
    apply_stimulus(0, 32'h08, 1'b1, 32'h11112222, rd, er, cy);
    apply_stimulus(0, 32'h08, 1'b0, 32'h0, rd, er, cy);
    check_output("raw_data", rd, 32'h11112222);
    apply_stimulus(0, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("cnt2_data", rd, 32'd2);

    // Reset while a read is in its READY cycle clears outputs immediately.
    start_xfer(0, 32'h08, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_output("pre_rst_prdata", prdata[0], 32'h11112222);
    rst_n = 1'b0;
    #1;
    check_output("rst_ready_pready", 32'(pready[0]), 32'd0);
    check_output("rst_ready_prdata", prdata[0], 32'h0);
    release_reset();

    // Reset during the wait state of a write drops the write.
    start_xfer(0, 32'h08, 1'b1, 32'h12345678);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("rst_wait_pready", 32'(pready[0]), 32'd0);
    check_output("rst_wait_pslverr", 32'(pslverr[0]), 32'd0);
    check_output("rst_wait_prdata", prdata[0], 32'h0);
    release_reset();
    apply_stimulus(0, 32'h08, 1'b0, 32'h0, rd, er, cy);
    check_output("rd8_after_rst", rd, 32'h0);
    apply_stimulus(0, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("cnt_after_rst", rd, 32'd0);

    // PSEL dropped during the wait state aborts without a commit.
    go_idle();
    @(posedge clk); #1;
    psel    = 3'b001;
    penable = 1'b0;
    paddr   = 32'h0C;
    pwrite  = 1'b1;
    pwdata  = 32'h00000099;
    @(posedge clk); #1;
    psel    = 3'b000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_output("abort_pready", 32'(pready[0]), 32'd0);
    end

    // PENABLE without a SETUP phase is ignored.
    @(posedge clk); #1;
    psel    = 3'b001;
    penable = 1'b1;
    paddr   = 32'h04;
    pwrite  = 1'b1;
    pwdata  = 32'h77777777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("noset_pready", 32'(pready[0]), 32'd0);
    end
    go_idle();
    apply_stimulus(0, 32'h0C, 1'b0, 32'h0, rd, er, cy);
    check_output("rdC_after_abort", rd, 32'h0);
    apply_stimulus(0, 32'h04, 1'b0, 32'h0, rd, er, cy);
    check_output("rd4_noset", rd, 32'h0);
    apply_stimulus(0, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("cnt_after_abort", rd, 32'd0);

`ifdef APB_SLAVE_PSTRB_EN
    // Byte strobes: partial write, then an all-zero strobe write.
    pstrb = 4'hF;
    apply_stimulus(0, 32'h0C, 1'b1, 32'hFFFFFFFF, rd, er, cy);
    pstrb = 4'b0101;
    apply_stimulus(0, 32'h0C, 1'b1, 32'h00000000, rd, er, cy);
    pstrb = 4'hF;
    apply_stimulus(0, 32'h0C, 1'b0, 32'h0, rd, er, cy);
    check_output("strb_data", rd, 32'hFF00FF00);
    pstrb = 4'h0;
    apply_stimulus(0, 32'h0C, 1'b1, 32'h12345678, rd, er, cy);
    check_output("strb0_err", 32'(er), 32'd0);
    pstrb = 4'hF;
    apply_stimulus(0, 32'h0C, 1'b0, 32'h0, rd, er, cy);
    check_output("strb0_data", rd, 32'hFF00FF00);
    apply_stimulus(0, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("strb_cnt", rd, 32'd3);
`endif

    // Zero wait states: READY in the first ACCESS cycle.
    go_idle();
    apply_stimulus(1, 32'h00, 1'b1, 32'hCAFEF00D, rd, er, cy);
    check_output("w0_wr_cycles", 32'(cy), 32'd2);
    apply_stimulus(1, 32'h00, 1'b0, 32'h0, rd, er, cy);
    check_output("w0_rd_cycles", 32'(cy), 32'd2);
    check_output("w0_rd_data", rd, 32'hCAFEF00D);
    apply_stimulus(1, 32'h3C, 1'b0, 32'h0, rd, er, cy);
    check_output("w0_cnt", rd, 32'd1);

    // Fifteen wait states: READY in the 16th ACCESS cycle.
    go_idle();
    apply_stimulus(2, 32'h10, 1'b1, 32'h0BADCAFE, rd, er, cy);
    check_output("w15_wr_cycles", 32'(cy), 32'd17);
    apply_stimulus(2, 32'h10, 1'b0, 32'h0, rd, er, cy);
    check_output("w15_rd_cycles", 32'(cy), 32'd17);
    check_output("w15_rd_data", rd, 32'h0BADCAFE);
    apply_stimulus(2, 32'h40, 1'b0, 32'h0, rd, er, cy);
    check_output("w15_oor_err", 32'(er), 32'd1);

    go_idle();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
